// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM states,
// parity-type encodings and the fixed line levels of start and stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator, shared by the transmitter (parity insertion)
// and the receiver (parity check). Even parity is the XOR of all data bits;
// odd parity is its inverse.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serializer running on the divided baud clock: one line bit per
// cycle. Accepts a word over a valid/busy handshake, then emits start bit,
// data LSB-first, optional parity and STOP_BITS stop bits. o_busy falls during
// the last stop bit so a request taken at that edge follows with no idle gap.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    uart_state_e           state;
    uart_state_e           state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic [CNT_W-1:0]      bit_idx_nxt;
    logic [DATA_WIDTH-1:0] shadow_data;
    logic                  shadow_par_en;
    logic                  shadow_par_typ;
    logic                  tx_nxt;
    logic                  busy_nxt;
    logic                  load;
    logic                  accept;
    logic                  par_bit;

    // A request is only taken while the line reports not-busy.
    assign accept      = i_data_valid & ~o_busy;
    assign bit_idx_nxt = bit_cnt + 1'b1;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (shadow_data),
        .par_typ (shadow_par_typ),
        .par_bit (par_bit)
    );

    // Next state plus the registered line/busy values for the coming bit period.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = STOP_BIT;
        busy_nxt    = 1'b0;
        load        = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    tx_nxt    = START_BIT;
                    busy_nxt  = 1'b1;
                    load      = 1'b1;
                end
            end
            START: begin
                state_nxt   = DATA;
                bit_cnt_nxt = '0;
                tx_nxt      = shadow_data[0];
                busy_nxt    = 1'b1;
            end
            DATA: begin
                if (bit_cnt == LAST_DATA) begin
                    bit_cnt_nxt = '0;
                    if (shadow_par_en) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = STOP;
                        busy_nxt  = (LAST_STOP != '0);
                    end
                end else begin
                    bit_cnt_nxt = bit_idx_nxt;
                    tx_nxt      = shadow_data[bit_idx_nxt];
                    busy_nxt    = 1'b1;
                end
            end
            PARITY: begin
                state_nxt   = STOP;
                bit_cnt_nxt = '0;
                busy_nxt    = (LAST_STOP != '0);
            end
            STOP: begin
                if (bit_cnt == LAST_STOP) begin
                    if (accept) begin
                        state_nxt = START;
                        tx_nxt    = START_BIT;
                        busy_nxt  = 1'b1;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_idx_nxt;
                    busy_nxt    = (bit_idx_nxt != LAST_STOP);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any frame with the line high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            o_tx    <= STOP_BIT;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            o_tx    <= tx_nxt;
            o_busy  <= busy_nxt;
        end
    end

    // Shadow copy of the request so the inputs may change once it is accepted.
    always_ff @(posedge i_clk) begin
        if (load) begin
            shadow_data    <= i_data;
            shadow_par_en  <= i_par_en;
            shadow_par_typ <= i_par_typ;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: two instances (one and two stop bits) driven by
// directed steps; expected line/busy values per bit period are queued when a
// request is driven and popped one per cycle. An empty queue means idle line.
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] d1, d2;
    logic       v1, v2, pe1, pt1, pe2, pt2;
    logic       tx1, busy1, tx2, busy2;

    typedef struct {
        logic [1:0] tb;
        string      tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (d1),
        .i_data_valid (v1),
        .i_par_en     (pe1),
        .i_par_typ    (pt1),
        .o_tx         (tx1),
        .o_busy       (busy1)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (d2),
        .i_data_valid (v2),
        .i_par_en     (pe2),
        .i_par_typ    (pt2),
        .o_tx         (tx2),
        .o_busy       (busy2)
    );

    // Expected {tx, busy} for every bit period of one frame.
    function automatic void push_frame(input int which, input logic [7:0] d,
                                       input logic pe, input logic pt,
                                       input int sb, input string nm);
        exp_t f[$];
        exp_t e;
        e.tb  = {1'b0, 1'b1};
        e.tag = {nm, ".start"};
        f.push_back(e);
        for (int k = 0; k < 8; k++) begin
            e.tb  = {d[k], 1'b1};
            e.tag = $sformatf("%s.d%0d", nm, k);
            f.push_back(e);
        end
        if (pe) begin
            e.tb  = {((pt == PAR_EVEN) ? (^d) : ~(^d)), 1'b1};
            e.tag = {nm, ".parity"};
            f.push_back(e);
        end
        for (int s = 0; s < sb; s++) begin
            e.tb  = {1'b1, ((s == sb - 1) ? 1'b0 : 1'b1)};
            e.tag = $sformatf("%s.stop%0d", nm, s);
            f.push_back(e);
        end
        foreach (f[i]) begin
            if (which == 1) q1.push_back(f[i]);
            else            q2.push_back(f[i]);
        end
    endfunction

    task automatic step();
        exp_t e1, e2;
        @(negedge i_clk);
        if (q1.size() > 0) e1 = q1.pop_front();
        else begin e1.tb = 2'b10; e1.tag = "dut1.idle"; end
        if (q2.size() > 0) e2 = q2.pop_front();
        else begin e2.tb = 2'b10; e2.tag = "dut2.idle"; end
        compared++;
        assert ({tx1, busy1} === e1.tb) else begin
            mismatched++;
            $error("FAIL %s: observed tx,busy=%b required %b", e1.tag, {tx1, busy1}, e1.tb);
        end
        compared++;
        assert ({tx2, busy2} === e2.tb) else begin
            mismatched++;
            $error("FAIL %s: observed tx,busy=%b required %b", e2.tag, {tx2, busy2}, e2.tb);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1;
        d1 = 8'h00; v1 = 1'b0; pe1 = 1'b0; pt1 = 1'b0;
        d2 = 8'h00; v2 = 1'b0; pe2 = 1'b0; pt2 = 1'b0;
        @(posedge i_clk);
        steps(2);
        i_rst = 1'b0;
        steps(2);

        // 8N1, 0xA5
        d1 = 8'hA5; pe1 = 1'b0; pt1 = PAR_EVEN; v1 = 1'b1;
        push_frame(1, 8'hA5, 1'b0, PAR_EVEN, 1, "n81_a5");
        step();
        v1 = 1'b0;
        steps(11);

        // Even parity, 0xA5; inputs scrambled after accept
        d1 = 8'hA5; pe1 = 1'b1; pt1 = PAR_EVEN; v1 = 1'b1;
        push_frame(1, 8'hA5, 1'b1, PAR_EVEN, 1, "even_a5");
        step();
        v1 = 1'b0; d1 = 8'h00; pe1 = 1'b0; pt1 = PAR_ODD;
        steps(12);

        // Odd parity, 0x01
        d1 = 8'h01; pe1 = 1'b1; pt1 = PAR_ODD; v1 = 1'b1;
        push_frame(1, 8'h01, 1'b1, PAR_ODD, 1, "odd_01");
        step();
        v1 = 1'b0;
        steps(12);

        // Request for 0x12 while busy is ignored
        d1 = 8'h96; pe1 = 1'b0; pt1 = PAR_EVEN; v1 = 1'b1;
        push_frame(1, 8'h96, 1'b0, PAR_EVEN, 1, "busy_96");
        step();
        v1 = 1'b0;
        steps(3);
        d1 = 8'h12; pe1 = 1'b1; v1 = 1'b1;
        step();
        v1 = 1'b0;
        steps(5);
        steps(4);

        // Back-to-back with two stop bits, valid held high
        d2 = 8'h55; v2 = 1'b1;
        push_frame(2, 8'h55, 1'b0, PAR_EVEN, 2, "b2b_55");
        step();
        d2 = 8'hFF;
        push_frame(2, 8'hFF, 1'b0, PAR_EVEN, 2, "b2b_ff");
        steps(10);
        step();
        v2 = 1'b0;
        steps(10);
        steps(3);

        // Reset during data bit 3, then a fresh 0x3C frame
        d1 = 8'h00; pe1 = 1'b0; v1 = 1'b1;
        push_frame(1, 8'h00, 1'b0, PAR_EVEN, 1, "rst_00");
        step();
        v1 = 1'b0;
        steps(4);
        i_rst = 1'b1;
        q1.delete();
        q2.delete();
        step();
        i_rst = 1'b0;
        step();
        d1 = 8'h3C; v1 = 1'b1;
        push_frame(1, 8'h3C, 1'b0, PAR_EVEN, 1, "post_rst_3c");
        step();
        v1 = 1'b0;
        steps(9);
        steps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
